// File: rtl/sdram_arbit.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arbit
//  Brief    : SDRAM command-bus arbiter. Grants the shared command/address/
//             data bus to the init, auto-refresh, write and read sub-blocks
//             with priority init > refresh > write/read round-robin, and
//             releases a stuck grant through a watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_arbit #(
    parameter int TMO_CYC = 1023,
    parameter int CNT_W   = 10
) (
    input  logic        sclk,
    input  logic        s_rst,
    // init block
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    // auto-refresh block
    input  logic        ref_req,
    input  logic        ref_end,
    input  logic [3:0]  ref_cmd,
    input  logic [12:0] ref_addr,
    // write block
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_bank,
    input  logic [12:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        wr_data_oe,
    // read block
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_bank,
    input  logic [12:0] rd_addr,
    // grants and status
    output logic        ref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        ref_pend,
    output logic        tmo_err,
    // SDRAM bus
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_bank,
    output logic [12:0] sdram_addr,
    inout  wire  [15:0] sdram_dq
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_TMO = CNT_W'(TMO_CYC);
    localparam logic [3:0]       C_NOP = 4'b0111;

    state_t             r_state;
    logic               r_last_wr;   // 1: last write/read grant went to write
    logic [CNT_W-1:0]   r_wd_cnt;
    logic               r_ref_en;
    logic               r_wr_en;
    logic               r_rd_en;
    logic               r_tmo_err;

    logic               w_tmo;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [3:0]         w_cmd;
    logic [1:0]         w_bank;
    logic [12:0]        w_addr;

    // Watchdog expiry and saturating increment; the counter cannot wrap.
    assign w_tmo     = (r_wd_cnt == C_TMO);
    assign w_cnt_inc = w_tmo ? r_wd_cnt : r_wd_cnt + CNT_W'(1);

    // Arbitration FSM with registered one-cycle grant pulses and watchdog.
    // The watchdog counter is cleared by default so that any state change
    // restarts it; only the "stay" branches of watched states advance it.
    // An end pulse outranks a simultaneous timeout.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_state   <= S_INIT;
            r_last_wr <= 1'b0;
            r_wd_cnt  <= '0;
            r_ref_en  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_ref_en  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tmo_err <= 1'b0;
            r_wd_cnt  <= '0;
            case (r_state)
                S_INIT: begin
                    if (init_end) begin
                        r_state <= S_ARBIT;
                    end
                end
                S_ARBIT: begin
                    if (ref_req) begin
                        r_state  <= S_AREF;
                        r_ref_en <= 1'b1;
                    end else if (wr_req && rd_req) begin
                        if (r_last_wr) begin
                            r_state   <= S_READ;
                            r_rd_en   <= 1'b1;
                            r_last_wr <= 1'b0;
                        end else begin
                            r_state   <= S_WRITE;
                            r_wr_en   <= 1'b1;
                            r_last_wr <= 1'b1;
                        end
                    end else if (wr_req) begin
                        r_state   <= S_WRITE;
                        r_wr_en   <= 1'b1;
                        r_last_wr <= 1'b1;
                    end else if (rd_req) begin
                        r_state   <= S_READ;
                        r_rd_en   <= 1'b1;
                        r_last_wr <= 1'b0;
                    end
                end
                S_AREF: begin
                    if (ref_end) begin
                        r_state <= S_ARBIT;
                    end else if (w_tmo) begin
                        r_state   <= S_ARBIT;
                        r_tmo_err <= 1'b1;
                    end else begin
                        r_wd_cnt <= w_cnt_inc;
                    end
                end
                S_WRITE: begin
                    if (wr_end) begin
                        r_state <= S_ARBIT;
                    end else if (w_tmo) begin
                        r_state   <= S_ARBIT;
                        r_tmo_err <= 1'b1;
                    end else begin
                        r_wd_cnt <= w_cnt_inc;
                    end
                end
                S_READ: begin
                    if (rd_end) begin
                        r_state <= S_ARBIT;
                    end else if (w_tmo) begin
                        r_state   <= S_ARBIT;
                        r_tmo_err <= 1'b1;
                    end else begin
                        r_wd_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    // Command/bank/address mux selected by the current owner.
    always_comb begin
        w_cmd  = C_NOP;
        w_bank = 2'd0;
        w_addr = 13'd0;
        case (r_state)
            S_INIT: begin
                w_cmd  = init_cmd;
                w_addr = init_addr;
            end
            S_AREF: begin
                w_cmd  = ref_cmd;
                w_addr = ref_addr;
            end
            S_WRITE: begin
                w_cmd  = wr_cmd;
                w_bank = wr_bank;
                w_addr = wr_addr;
            end
            S_READ: begin
                w_cmd  = rd_cmd;
                w_bank = rd_bank;
                w_addr = rd_addr;
            end
            default: begin
                w_cmd  = C_NOP;
                w_bank = 2'd0;
                w_addr = 13'd0;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
    assign sdram_bank = w_bank;
    assign sdram_addr = w_addr;

    // Only the write owner may drive data, and only when it asks to.
    assign sdram_dq = ((r_state == S_WRITE) && wr_data_oe) ? wr_data : 16'bz;

    // Ask an active burst to close early so refresh is not starved.
    assign ref_pend = ref_req && ((r_state == S_WRITE) || (r_state == S_READ));

    assign ref_en  = r_ref_en;
    assign wr_en   = r_wr_en;
    assign rd_en   = r_rd_en;
    assign tmo_err = r_tmo_err;

endmodule
`default_nettype wire
